// File: rtl/pill_fill_ctrl.sv
// Pill bottling controller: counts pills into bottles and bottles into a batch,
// driving the feed valve and pausing for bottle swaps.
module pill_fill_ctrl #(
    parameter int unsigned SWAP_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       isWork,
    input  logic       pill_in,
    input  logic [3:0] pill_maxL,
    input  logic [3:0] pill_maxH,
    input  logic [3:0] bot_maxL,
    input  logic [3:0] bot_maxH,
    output logic [3:0] pill_seq_L,
    output logic [3:0] pill_seq_H,
    output logic [3:0] bot_seq_L,
    output logic [3:0] bot_seq_H,
    output logic       valve_open,
    output logic       bot_done,
    output logic       batch_done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SWAP  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state_reg;
    logic [7:0] pill_seq_reg;
    logic [7:0] bot_seq_reg;
    logic [7:0] pill_max_reg;
    logic [7:0] bot_max_reg;
    logic [3:0] swap_cnt_reg;
    logic       pill_in_q_reg;
    logic       valve_reg;
    logic       bot_done_reg;
    logic       batch_done_reg;

    logic       pill_edge;
    logic       cfg_valid;
    logic [7:0] pill_next;
    logic [7:0] bot_next;
    logic [3:0] cfg_digit [4];
    logic [3:0] digit_ok;

    // Two-digit BCD increment; the tens digit wraps 9 -> 0.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    assign cfg_digit[0] = pill_maxL;
    assign cfg_digit[1] = pill_maxH;
    assign cfg_digit[2] = bot_maxL;
    assign cfg_digit[3] = bot_maxH;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit_chk
            assign digit_ok[gi] = (cfg_digit[gi] <= 4'd9);
        end
    endgenerate

    always_comb begin
        pill_edge = pill_in & ~pill_in_q_reg;
        cfg_valid = (&digit_ok) && ({pill_maxH, pill_maxL} != 8'h00)
                    && ({bot_maxH, bot_maxL} != 8'h00);
        pill_next = bcd_inc(pill_seq_reg);
        bot_next  = bcd_inc(bot_seq_reg);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            pill_seq_reg   <= 8'h00;
            bot_seq_reg    <= 8'h00;
            pill_max_reg   <= 8'h00;
            bot_max_reg    <= 8'h00;
            swap_cnt_reg   <= 4'd0;
            pill_in_q_reg  <= 1'b0;
            valve_reg      <= 1'b0;
            bot_done_reg   <= 1'b0;
            batch_done_reg <= 1'b0;
        end else begin
            pill_in_q_reg <= pill_in;
            bot_done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    pill_seq_reg   <= 8'h00;
                    bot_seq_reg    <= 8'h00;
                    valve_reg      <= 1'b0;
                    batch_done_reg <= 1'b0;
                    if (isWork && cfg_valid) begin
                        state_reg    <= FILL;
                        valve_reg    <= 1'b1;
                        pill_max_reg <= {pill_maxH, pill_maxL};
                        bot_max_reg  <= {bot_maxH, bot_maxL};
                    end
                end
                FILL: begin
                    if (!isWork) begin
                        state_reg <= PAUSE;
                        valve_reg <= 1'b0;
                    end else if (pill_edge) begin
                        if (pill_next == pill_max_reg) begin
                            // Bottle complete: close the valve on the same edge.
                            pill_seq_reg <= 8'h00;
                            bot_seq_reg  <= bot_next;
                            bot_done_reg <= 1'b1;
                            valve_reg    <= 1'b0;
                            if (bot_next == bot_max_reg) begin
                                state_reg      <= DONE;
                                batch_done_reg <= 1'b1;
                            end else begin
                                state_reg    <= SWAP;
                                swap_cnt_reg <= 4'(SWAP_CYCLES - 1);
                            end
                        end else begin
                            pill_seq_reg <= pill_next;
                        end
                    end
                end
                SWAP: begin
                    if (swap_cnt_reg == 4'd0) begin
                        if (isWork) begin
                            state_reg <= FILL;
                            valve_reg <= 1'b1;
                        end else begin
                            state_reg <= PAUSE;
                        end
                    end else begin
                        swap_cnt_reg <= swap_cnt_reg - 4'd1;
                    end
                end
                PAUSE: begin
                    if (isWork) begin
                        state_reg <= FILL;
                        valve_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (!isWork) begin
                        state_reg      <= IDLE;
                        batch_done_reg <= 1'b0;
                        pill_seq_reg   <= 8'h00;
                        bot_seq_reg    <= 8'h00;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    valve_reg      <= 1'b0;
                    batch_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pill_seq_L = pill_seq_reg[3:0];
    assign pill_seq_H = pill_seq_reg[7:4];
    assign bot_seq_L  = bot_seq_reg[3:0];
    assign bot_seq_H  = bot_seq_reg[7:4];
    assign valve_open = valve_reg;
    assign bot_done   = bot_done_reg;
    assign batch_done = batch_done_reg;
    assign state      = state_reg;

endmodule
